// File: rtl/fft_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_sched_if
// Purpose  : Bundle of control, butterfly-descriptor and write-back signals
//            between the radix-2 FFT scheduler and its datapath.
// Ports    : master modport = scheduler side (drives busy/done/err, tw_addr,
//            bf_valid/bf_addr_a/bf_addr_b/bf_stage; samples start, bf_ready,
//            wb_valid). The slave modport is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_sched_if #(
    parameter int LOG2N = 3
);
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic [LOG2N-1:0] tw_addr;
    logic             bf_valid;
    logic             bf_ready;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [2:0]       bf_stage;
    logic             wb_valid;

    modport master (
        input  start, bf_ready, wb_valid,
        output busy, done, err, tw_addr, bf_valid, bf_addr_a, bf_addr_b, bf_stage
    );

    modport slave (
        output start, bf_ready, wb_valid,
        input  busy, done, err, tw_addr, bf_valid, bf_addr_a, bf_addr_b, bf_stage
    );
endinterface
`default_nettype wire

// File: rtl/fft_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_sched
// Purpose  : Stage/butterfly scheduler for a radix-2 DIT FFT. Walks LOG2N
//            stages, issuing one butterfly descriptor per accepted cycle,
//            steers the twiddle ROM address so its registered output lines up
//            with the descriptor on the bus, and holds each new stage until
//            every butterfly of the previous one has been written back.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - fft_sched_if.master (start/busy/done/err, tw_addr,
//                   bf_valid/bf_ready/bf_addr_a/bf_addr_b/bf_stage, wb_valid)
// Revision : 1.0 - initial release
// ============================================================================
module fft_sched #(
    parameter int LOG2N = 3
) (
    input  logic        clk,
    input  logic        rst,
    fft_sched_if.master bus
);
    localparam int c_HALF_N = 1 << (LOG2N - 1);
    localparam int c_JW     = LOG2N - 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [2:0]       c_LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [LOG2N-1:0] c_ONE        = LOG2N'(1);
    localparam logic [LOG2N-1:0] c_LAST_WB    = LOG2N'(c_HALF_N - 1);
    localparam logic [c_JW-1:0]  c_J_ONE      = c_JW'(1);
    localparam logic [c_JW-1:0]  c_J_LAST     = {c_JW{1'b1}};

    logic [1:0]       state_q,    state_d;
    logic [2:0]       stage_q,    stage_d;
    logic [c_JW-1:0]  j_q,        j_d;
    logic [LOG2N-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [LOG2N-1:0] wb_cnt_q,   wb_cnt_d;
    logic             vld_q,      vld_d;
    logic [LOG2N-1:0] addr_a_q,   addr_a_d;
    logic [LOG2N-1:0] addr_b_q,   addr_b_d;
    logic [2:0]       bstage_q,   bstage_d;
    logic [LOG2N-1:0] tw_hold_q,  tw_hold_d;
    logic             err_q,      err_d;

    // Address / twiddle generation for the counters (stage_q, j_q).
    // addr_a inserts a zero bit at position s into j; addr_b sets that bit.
    logic [LOG2N-1:0] w_half, w_p, w_g, w_addr_a, w_addr_b, w_tw;

    always_comb begin
        w_half   = c_ONE << stage_q;
        w_p      = {1'b0, j_q} & (w_half - c_ONE);
        w_g      = {1'b0, j_q} >> stage_q;
        w_addr_a = (w_g << (stage_q + 3'd1)) | w_p;
        w_addr_b = w_addr_a | w_half;
        w_tw     = w_p << (c_LAST_STAGE - stage_q);
    end

    logic w_load, w_xfer, w_active, w_wb_ok, w_wb_bad, w_stage_done;

    always_comb begin
        w_load       = (state_q == c_ISSUE) && (!vld_q || bus.bf_ready);
        w_xfer       = vld_q && bus.bf_ready;
        w_active     = (state_q == c_ISSUE) || (state_q == c_DRAIN);
        // A write-back needs an outstanding butterfly; one transferring in the
        // same cycle counts as outstanding.
        w_wb_ok      = bus.wb_valid && w_active && ((xfer_cnt_q != wb_cnt_q) || w_xfer);
        w_wb_bad     = bus.wb_valid && !w_wb_ok;
        w_stage_done = (state_q == c_DRAIN) && w_wb_ok && (wb_cnt_q == c_LAST_WB);
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        j_d        = j_q;
        xfer_cnt_d = xfer_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        vld_d      = vld_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        bstage_d   = bstage_q;
        tw_hold_d  = tw_hold_q;
        err_d      = err_q;

        if (w_xfer && w_active) begin
            xfer_cnt_d = xfer_cnt_q + c_ONE;
        end
        if (w_wb_ok) begin
            wb_cnt_d = wb_cnt_q + c_ONE;
        end
        if (w_wb_bad) begin
            err_d = 1'b1;
        end

        // Output slot: load a fresh descriptor, or retire the held one.
        if (w_load) begin
            vld_d     = 1'b1;
            addr_a_d  = w_addr_a;
            addr_b_d  = w_addr_b;
            bstage_d  = stage_q;
            tw_hold_d = w_tw;
        end else if (w_xfer) begin
            vld_d = 1'b0;
        end

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    state_d    = c_ISSUE;
                    stage_d    = 3'd0;
                    j_d        = '0;
                    xfer_cnt_d = '0;
                    wb_cnt_d   = '0;
                    err_d      = 1'b0;
                end
            end
            c_ISSUE: begin
                if (w_load) begin
                    j_d = j_q + c_J_ONE;
                    if (j_q == c_J_LAST) begin
                        state_d = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (w_stage_done) begin
                    j_d        = '0;
                    xfer_cnt_d = '0;
                    wb_cnt_d   = '0;
                    if (stage_q == c_LAST_STAGE) begin
                        state_d = c_DONE;
                    end else begin
                        state_d = c_ISSUE;
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_IDLE;
            stage_q    <= 3'd0;
            j_q        <= '0;
            xfer_cnt_q <= '0;
            wb_cnt_q   <= '0;
            vld_q      <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            bstage_q   <= 3'd0;
            tw_hold_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            j_q        <= j_d;
            xfer_cnt_q <= xfer_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            vld_q      <= vld_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            bstage_q   <= bstage_d;
            tw_hold_q  <= tw_hold_d;
            err_q      <= err_d;
        end
    end

    // The ROM registers tw_addr on the same edge that loads the slot, so in a
    // load cycle it sees the counters' twiddle; otherwise the held one, which
    // keeps ROM dout stable through stalls.
    assign bus.tw_addr   = w_load ? w_tw : tw_hold_q;
    assign bus.busy      = w_active;
    assign bus.done      = (state_q == c_DONE);
    assign bus.err       = err_q;
    assign bus.bf_valid  = vld_q;
    assign bus.bf_addr_a = addr_a_q;
    assign bus.bf_addr_b = addr_b_q;
    assign bus.bf_stage  = bstage_q;
endmodule
`default_nettype wire

// File: doc/fft_sched.md
# fft_sched

Stage/butterfly scheduler for the radix-2 decimation-in-time FFT datapath. On `start` it walks all LOG2N stages, issuing one butterfly per accepted cycle with its two data-memory addresses. It drives the twiddle ROM address so the ROM's registered output is aligned with each issued butterfly. It also enforces a stage barrier: no butterfly of stage s+1 issues until every butterfly of stage s has been written back.

## Interface
- LOG2N, 3, log2 of FFT size N. Legal range is 2..6. Address width is LOG2N.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a transform when sampled high in IDLE; ignored otherwise.
- busy  out  1  high from the cycle after `start` is accepted until the `done` cycle; low in the `done` cycle.
- done  out  1  one-cycle pulse when the last write-back of the last stage has been counted.
- err  out  1  sticky write-back-overflow flag; cleared when `start` is accepted.
- tw_addr  out  LOG2N  twiddle ROM address; the ROM has a 1-cycle synchronous read.
- bf_valid  out  1  butterfly descriptor valid.
- bf_ready  in  1  butterfly unit accepts the descriptor; a transfer occurs when bf_valid & bf_ready.
- bf_addr_a  out  LOG2N  upper-leg data address.
- bf_addr_b  out  LOG2N  lower-leg data address.
- bf_stage  out  3  stage index of the descriptor.
- wb_valid  in  1  one pulse per completed butterfly write-back.

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: walks the butterfly counter of the current stage.
  - DRAIN: all N/2 butterflies of the stage are issued; waits for write-backs.
  - DONE: one cycle; `done`=1, then returns to IDLE.
- Transitions:
  - IDLE→ISSUE on `start`.
  - ISSUE→DRAIN when the last butterfly (j=N/2-1) is loaded into the output slot.
  - DRAIN→ISSUE (stage+1, j=0) in the cycle after the N/2-th wb_valid of the stage is sampled, if stage < LOG2N-1.
  - DRAIN→DONE under the same condition at stage LOG2N-1.
- Address generation for stage s, butterfly j (0..N/2-1):
  - half = 2^s
  - p = j mod half
  - g = j >> s
  - addr_a = g·2^(s+1) + p
  - addr_b = addr_a + half
  - twiddle index = p << (LOG2N-1-s); range 0..N/2-1, W_N^k.
- Output slot (bf_valid, bf_addr_a/b, bf_stage):
  - Loads from the counters when (!bf_valid | bf_ready) and state is ISSUE.
  - Clears bf_valid on a transfer when no new item loads.
- Twiddle alignment:
  - In a load cycle, tw_addr = twiddle index of the counters.
  - Otherwise, tw_addr = twiddle index of the held descriptor, so ROM dout remains valid during stalls.
  - ROM dout always corresponds to the descriptor on bf_*.
- Write-back counter:
  - Counts wb_valid pulses per stage and resets to 0 at each stage advance.
  - Outstanding = transfers minus write-backs in the current stage.
  - A wb_valid with outstanding = 0 (including in IDLE) is not counted and sets `err`.
  - A wb_valid coinciding with a transfer is legal and counted.

## Timing
- Reset (asynchronous, immediate): state IDLE, counters 0, and every output 0 (busy, done, err, tw_addr, bf_valid, bf_addr_a, bf_addr_b, bf_stage).
- `start` sampled at edge T:
  - busy=1 and tw_addr=0 during cycle T+1.
  - bf_valid=1 with stage 0, j=0 from T+2.
- With bf_ready=1, a stage issues N/2 descriptors on consecutive cycles.
- Stall: bf_valid=1 & bf_ready=0 holds bf_addr_a, bf_addr_b, bf_stage and tw_addr unchanged, with no counter advance.
- Stage advance: the first descriptor of the next stage appears 2 cycles after the edge that samples the final write-back.
- `done` is asserted 1 cycle after the final write-back edge; busy is 0 in that same cycle.
- `start` during busy or DONE is ignored.
- Reset mid-transform aborts immediately; the next `start` begins again at stage 0.

## Test plan
- Basic sequencing, LOG2N=3:
  - Stimulus: start; bf_ready=1; wb_valid echoed 3 cycles after each transfer.
  - Required stage 0 pairs: (0,1) (2,3) (4,5) (6,7), tw 0,0,0,0.
  - Required stage 1 pairs: (0,2) (1,3) (4,6) (5,7), tw 0,2,0,2.
  - Required stage 2 pairs: (0,4) (1,5) (2,6) (3,7), tw 0,1,2,3.
  - `done` pulses once; busy falls in the `done` cycle.
- Stall: deassert bf_ready for 3 cycles on stage 2, j=1 -> bf_addr_a=1, bf_addr_b=5 and tw_addr=1 held for 3 cycles; ROM dout stays W^1; no descriptor is skipped or duplicated.
- Barrier: withhold the 4th wb_valid of stage 0 for 10 cycles -> bf_valid=0 throughout; stage 1, j=0 appears exactly 2 cycles after that wb_valid.
- Error: wb_valid while IDLE -> err=1 and stays 1; the next start clears it; a normal run then completes with err=0.
- Reset abort: assert rst during stage 1 -> all outputs are 0 in the same cycle; after a new start, the first descriptor is stage 0 (0,1), tw 0.
- Ignored start: pulse start during stage 1 -> the sequence is unchanged and exactly one `done` occurs.
